// File: rtl/led_fx_sequencer.sv
// led_fx_sequencer
// Multi-channel LED effect controller. Each channel holds an effect
// configuration (OFF, STATIC, BLINK, BREATH). A single duty-update engine
// visits every channel once per effect tick, one channel per clock. All
// channels share one free-running PWM counter. A per-channel shadow
// register latches the duty only at the counter wrap, so a duty change can
// never cut a PWM period short.
module led_fx_sequencer #(
   parameter int NUM_CH     = 6,
   parameter int PWM_BITS   = 8,
   parameter int TICK_DIV   = 27000,
   parameter int STEP       = 4,
   parameter int ACTIVE_LOW = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic [2:0]          cmd_ch,
   input  logic [1:0]          cmd_mode,
   input  logic [PWM_BITS-1:0] cmd_level,
   input  logic [7:0]          cmd_rate,
   output logic [NUM_CH-1:0]   led_out,
   output logic                busy
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int EXT_W = PWM_BITS + 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);
   localparam logic [EXT_W-1:0]  STEP_X   = EXT_W'(STEP);
   localparam logic [NUM_CH-1:0] LED_POL  = (ACTIVE_LOW != 0) ? '1 : '0;

   typedef enum logic [1:0] {
      MODE_OFF    = 2'd0,
      MODE_STATIC = 2'd1,
      MODE_BLINK  = 2'd2,
      MODE_BREATH = 2'd3
   } mode_t;

   typedef enum logic {
      ST_IDLE,
      ST_UPDATE
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [IDX_W-1:0]     idx;
   logic [IDX_W-1:0]     idx_nxt;
   logic [DIV_W-1:0]     div_cnt;
   logic                 tick;
   logic                 cmd_accept;

   mode_t                ch_mode     [NUM_CH];
   logic [PWM_BITS-1:0]  ch_level    [NUM_CH];
   logic [7:0]           ch_rate     [NUM_CH];
   logic [7:0]           ch_rate_cnt [NUM_CH];
   logic [PWM_BITS-1:0]  ch_duty     [NUM_CH];
   logic [PWM_BITS-1:0]  ch_shadow   [NUM_CH];
   logic [NUM_CH-1:0]    ch_down;

   mode_t                cur_mode;
   logic [PWM_BITS-1:0]  cur_level;
   logic [PWM_BITS-1:0]  cur_duty;
   logic [7:0]           cur_rate;
   logic [7:0]           cur_rate_cnt;
   logic                 cur_down;

   logic [PWM_BITS-1:0]  upd_duty;
   logic [7:0]           upd_rate_cnt;
   logic                 upd_down;
   logic [EXT_W-1:0]     duty_x;
   logic [EXT_W-1:0]     duty_up;
   logic [EXT_W-1:0]     duty_dn;
   logic [PWM_BITS-1:0]  load_duty;

   logic [PWM_BITS-1:0]  pwm_cnt;
   logic [NUM_CH-1:0]    lit;

   assign tick       = (div_cnt == DIV_LAST);
   assign cmd_accept = cmd_valid && cmd_ready;
   assign load_duty  = ((cmd_mode == MODE_STATIC) || (cmd_mode == MODE_BLINK)) ? cmd_level : '0;

   // Effect tick divider: counts 0..TICK_DIV-1, tick is the last count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
      end else if (tick) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   // Sequencer state and channel index registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Sequencer next state: idle accepts commands, update walks all channels.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      cmd_ready = 1'b0;
      busy      = 1'b0;
      case (state)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            if (tick) begin
               state_nxt = ST_UPDATE;
               idx_nxt   = '0;
            end
         end
         ST_UPDATE: begin
            busy = 1'b1;
            if (idx == IDX_LAST) begin
               state_nxt = ST_IDLE;
               idx_nxt   = '0;
            end else begin
               idx_nxt = idx + 1'b1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   // Pick out the configuration of the channel the engine is visiting.
   always_comb begin
      cur_mode     = MODE_OFF;
      cur_level    = '0;
      cur_duty     = '0;
      cur_rate     = '0;
      cur_rate_cnt = '0;
      cur_down     = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (32'(idx) == c) begin
            cur_mode     = ch_mode[c];
            cur_level    = ch_level[c];
            cur_duty     = ch_duty[c];
            cur_rate     = ch_rate[c];
            cur_rate_cnt = ch_rate_cnt[c];
            cur_down     = ch_down[c];
         end
      end
   end

   // Effect step for the visited channel; breath math is one bit wider so it cannot wrap.
   always_comb begin
      upd_duty     = cur_duty;
      upd_rate_cnt = cur_rate_cnt;
      upd_down     = cur_down;
      duty_x       = {1'b0, cur_duty};
      duty_up      = duty_x + STEP_X;
      duty_dn      = duty_x - STEP_X;
      if (cur_rate_cnt != cur_rate) begin
         upd_rate_cnt = cur_rate_cnt + 8'd1;
      end else begin
         upd_rate_cnt = '0;
         case (cur_mode)
            MODE_OFF:    upd_duty = '0;
            MODE_STATIC: upd_duty = cur_level;
            MODE_BLINK:  upd_duty = (cur_duty == '0) ? cur_level : '0;
            MODE_BREATH: begin
               if (!cur_down) begin
                  if (duty_up >= {1'b0, cur_level}) begin
                     upd_duty = cur_level;
                     upd_down = 1'b1;
                  end else begin
                     upd_duty = duty_up[PWM_BITS-1:0];
                  end
               end else begin
                  if (duty_x <= STEP_X) begin
                     upd_duty = '0;
                     upd_down = 1'b0;
                  end else begin
                     upd_duty = duty_dn[PWM_BITS-1:0];
                  end
               end
            end
         endcase
      end
   end

   // Channel configuration: host commands (idle only) or the engine's step result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            ch_mode[c]     <= MODE_OFF;
            ch_level[c]    <= '0;
            ch_rate[c]     <= '0;
            ch_rate_cnt[c] <= '0;
            ch_duty[c]     <= '0;
         end
         ch_down <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (cmd_accept && (32'(cmd_ch) == c)) begin
               ch_mode[c]     <= mode_t'(cmd_mode);
               ch_level[c]    <= cmd_level;
               ch_rate[c]     <= cmd_rate;
               ch_rate_cnt[c] <= '0;
               ch_duty[c]     <= load_duty;
               ch_down[c]     <= 1'b0;
            end else if (busy && (32'(idx) == c)) begin
               ch_rate_cnt[c] <= upd_rate_cnt;
               ch_duty[c]     <= upd_duty;
               ch_down[c]     <= upd_down;
            end
         end
      end
   end

   // Shared PWM counter, with duty copied into the shadows only at the wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            ch_shadow[c] <= '0;
         end
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
         if (pwm_cnt == '1) begin
            for (int c = 0; c < NUM_CH; c++) begin
               ch_shadow[c] <= ch_duty[c];
            end
         end
      end
   end

   // PWM compare; an all-ones shadow means fully on for the whole period.
   always_comb begin
      lit = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         lit[c] = (pwm_cnt < ch_shadow[c]) || (ch_shadow[c] == '1);
      end
   end

   // Registered LED drive with board polarity applied.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_out <= LED_POL;
      end else begin
         led_out <= lit ^ LED_POL;
      end
   end

endmodule
